// File: rtl/ad1pmod_axil_pkg.sv
// ad1pmod_axil_pkg
// Shared constants and types for the AD1Pmod AXI4-Lite register slave.
// Optional feature macro: AD1PMOD_AXIL_DECERR_EN (see ad1pmod_axil_slave).

package ad1pmod_axil_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Software-visible register word and index
    typedef logic [1:0]  reg_idx_t;
    typedef logic [31:0] reg_word_t;

    localparam int NUM_REGS = 4;

    // Register map (index = address bits [3:2])
    localparam reg_idx_t REG_CTRL = 2'd0;
    localparam reg_idx_t REG_STAT = 2'd1;
    localparam reg_idx_t REG_CFG0 = 2'd2;
    localparam reg_idx_t REG_CFG1 = 2'd3;

    // Channel state encodings
    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/ad1pmod_strb_merge.sv
// ad1pmod_strb_merge
// Combinational byte-lane merge: each lane takes write data when its strobe
// is set, otherwise keeps the current register byte.

module ad1pmod_strb_merge
    import ad1pmod_axil_pkg::*;
(
    input  reg_word_t  i_old,
    input  reg_word_t  i_wdata,
    input  logic [3:0] i_wstrb,
    output reg_word_t  o_word
);

    // Select each byte from the new data or the held word
    always_comb begin
        o_word = i_old;
        for (int k = 0; k < 4; k++) begin
            if (i_wstrb[k]) begin
                o_word[8*k +: 8] = i_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/ad1pmod_axil_slave.sv
// ad1pmod_axil_slave
// AXI4-Lite responder holding four 32-bit registers for the AD1Pmod user
// logic. Write and read channels are independent single-beat FSMs.
//
// Optional feature macro: AD1PMOD_AXIL_DECERR_EN
//   defined   : address bits above [3:2] must be zero; other accesses get
//               SLVERR, leave the registers alone and read back zero.
//   undefined : upper address bits are ignored (registers alias), always OKAY.
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for AWVALID and WVALID together; READY pulses one cycle
//   W_RESP | BVALID/BRESP held until BREADY; no new AW/W accepted
//
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for ARVALID; ARREADY pulses one cycle
//   R_DATA | RVALID/RDATA/RRESP held until RREADY
//
// AWREADY/WREADY and ARREADY are registered, so the handshake cycle is the
// cycle after the valids are first seen. The data width parameter exists for
// interface compatibility; only 32 is meaningful.

module ad1pmod_axil_slave
    import ad1pmod_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,

    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,

    output reg_word_t [NUM_REGS-1:0]        reg_q,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    // Write channel state
    wr_state_t  r_wstate;
    logic       r_awready;
    logic       r_bvalid;
    logic [1:0] r_bresp;

    // Read channel state
    rd_state_t  r_rstate;
    logic       r_arready;
    logic       r_rvalid;
    logic [1:0] r_rresp;
    reg_word_t  r_rdata;

    // Register array
    reg_word_t [NUM_REGS-1:0] r_regs;

    logic                     w_wr_hs;
    logic                     w_rd_hs;
    logic                     w_aw_oob;
    logic                     w_ar_oob;
    logic                     w_wr_commit;
    reg_idx_t                 w_aw_idx;
    reg_idx_t                 w_ar_idx;
    reg_word_t [NUM_REGS-1:0] w_merged;

    // PROT is ignored, and address bits [1:0] never matter
    logic w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign w_aw_idx = S_AXI_AWADDR[3:2];
    assign w_ar_idx = S_AXI_ARADDR[3:2];

    // Handshake happens on the cycle the registered READY meets VALID
    assign w_wr_hs = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_hs = r_arready & S_AXI_ARVALID;

`ifdef AD1PMOD_AXIL_DECERR_EN
    // Anything above the 16-byte register window is rejected
    assign w_aw_oob = (S_AXI_AWADDR >> 4) != '0;
    assign w_ar_oob = (S_AXI_ARADDR >> 4) != '0;
`else
    assign w_aw_oob = 1'b0;
    assign w_ar_oob = 1'b0;
`endif

    assign w_wr_commit = w_wr_hs & ~w_aw_oob;

    // One merge per register so the update path is just a mux on the index
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_merge
        ad1pmod_strb_merge u_merge (
            .i_old   (r_regs[g]),
            .i_wdata (S_AXI_WDATA),
            .i_wstrb (S_AXI_WSTRB),
            .o_word  (w_merged[g])
        );
    end

    // Write channel FSM: joint AW/W acceptance, then hold B until accepted
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_hs) begin
                        r_awready <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_aw_oob ? RESP_SLVERR : RESP_OKAY;
                        r_wstate  <= W_RESP;
                    end else begin
                        // Only raise READY when both channels are present;
                        // drop it again if a master withdraws a valid.
                        r_awready <= ~r_awready & S_AXI_AWVALID & S_AXI_WVALID;
                    end
                end
                W_RESP: begin
                    r_awready <= 1'b0;
                    if (S_AXI_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: begin
                    r_awready <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_wstate  <= W_IDLE;
                end
            endcase
        end
    end

    // Register array update on a committed write handshake
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_regs <= '0;
        end else if (w_wr_commit) begin
            r_regs[w_aw_idx] <= w_merged[w_aw_idx];
        end
    end

    // Read channel FSM: sample the register at the AR handshake, hold R
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_rd_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        // r_regs is pre-write here, so a same-cycle write to
                        // the same register is not visible to this read.
                        r_rdata   <= w_ar_oob ? '0 : r_regs[w_ar_idx];
                        r_rresp   <= w_ar_oob ? RESP_SLVERR : RESP_OKAY;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= ~r_arready & S_AXI_ARVALID;
                    end
                end
                R_DATA: begin
                    r_arready <= 1'b0;
                    if (S_AXI_RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: begin
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rstate  <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;

    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

    assign reg_q         = r_regs;
    // Pulse even for an all-zero strobe so user logic still sees the access
    assign reg_wr_pulse  = w_wr_commit ? (4'b0001 << w_aw_idx) : 4'b0000;

endmodule

// File: tb/tb_ad1pmod_axil_slave.sv
// tb_ad1pmod_axil_slave
// Directed bench for ad1pmod_axil_slave. Builds with AD1PMOD_AXIL_DECERR_EN
// defined use a 6-bit address and add the out-of-window cases.

`timescale 1ns/1ps

module tb_ad1pmod_axil_slave;
    import ad1pmod_axil_pkg::*;

`ifdef AD1PMOD_AXIL_DECERR_EN
    localparam int AW = 6;
`else
    localparam int AW = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    reg_word_t [3:0] reg_q;
    logic [3:0]    pulse;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt [4] = '{0, 0, 0, 0};
    int base_cnt  [4];
    int n;

    always #5 clk = ~clk;

    ad1pmod_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_q         (reg_q),
        .reg_wr_pulse  (pulse)
    );

    // Count write pulses per register, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input logic [3:0] exp_pulse,
                            input string tag);
        int k;
        bready  = 1'b1;
        awaddr  = addr[AW-1:0];
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!awready && k < 20);
        chk1({tag, "_awready"}, awready, 1'b1);
        chk1({tag, "_wready"}, wready, 1'b1);
        chk({tag, "_pulse"}, {28'd0, pulse}, {28'd0, exp_pulse});
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk1({tag, "_bvalid"}, bvalid, 1'b1);
        chk({tag, "_bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
        k = 0;
        while (bvalid && k < 20) begin
            tick();
            k++;
        end
        chk1({tag, "_bdone"}, bvalid, 1'b0);
    endtask

    task automatic do_read(input int addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
        int k;
        rready  = 1'b1;
        araddr  = addr[AW-1:0];
        arvalid = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!arready && k < 20);
        chk1({tag, "_arready"}, arready, 1'b1);
        tick();
        arvalid = 1'b0;
        chk1({tag, "_rvalid"}, rvalid, 1'b1);
        chk({tag, "_rdata"}, rdata, exp_data);
        chk({tag, "_rresp"}, {30'd0, rresp}, {30'd0, exp_resp});
        tick();
        chk1({tag, "_rdone"}, rvalid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = 3'd0; awvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk1("rst_awready", awready, 1'b0);
        chk1("rst_wready", wready, 1'b0);
        chk1("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", {30'd0, bresp}, 32'd0);
        chk1("rst_arready", arready, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", {30'd0, rresp}, 32'd0);
        chk("rst_pulse", {28'd0, pulse}, 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_reg%0d", i), reg_q[i], 32'd0);
        rst = 1'b0;
        tick();

        // Sequential write then readback
        for (int i = 0; i < 4; i++) base_cnt[i] = pulse_cnt[i];
        do_write('h0, 32'h1, 4'hF, RESP_OKAY, 4'b0001, "seq_w0");
        do_write('h4, 32'h2, 4'hF, RESP_OKAY, 4'b0010, "seq_w1");
        do_write('h8, 32'h3, 4'hF, RESP_OKAY, 4'b0100, "seq_w2");
        do_write('hC, 32'h4, 4'hF, RESP_OKAY, 4'b1000, "seq_w3");
        for (int i = 0; i < 4; i++)
            chk($sformatf("seq_pulsecnt%0d", i), pulse_cnt[i] - base_cnt[i], 32'd1);
        chk("seq_regq0", reg_q[0], 32'h1);
        chk("seq_regq3", reg_q[3], 32'h4);
        do_read('h0, 32'h1, RESP_OKAY, "seq_r0");
        do_read('h4, 32'h2, RESP_OKAY, "seq_r1");
        do_read('h8, 32'h3, RESP_OKAY, "seq_r2");
        do_read('hC, 32'h4, RESP_OKAY, "seq_r3");

        // Byte strobes
        do_write('h4, 32'hFFFF_FFFF, 4'hF, RESP_OKAY, 4'b0010, "strb_w0");
        do_write('h4, 32'h1234_5678, 4'b0101, RESP_OKAY, 4'b0010, "strb_w1");
        chk("strb_regq1", reg_q[1], 32'hFF34_FF78);
        do_read('h4, 32'hFF34_FF78, RESP_OKAY, "strb_r");

        // Zero strobe: pulse still fires, register unchanged
        do_write('h8, 32'hDEAD_BEEF, 4'b0000, RESP_OKAY, 4'b0100, "zstrb");
        chk("zstrb_regq2", reg_q[2], 32'h3);

        // Low address bits ignored
        do_write('h7, 32'hA5A5_A5A5, 4'hF, RESP_OKAY, 4'b0010, "unal_w");
        do_read('h5, 32'hA5A5_A5A5, RESP_OKAY, "unal_r");

        // Skewed channels: AW five cycles ahead of W
        bready = 1'b1;
        awaddr = 'hC; wdata = 32'hCAFE_0004; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1($sformatf("skew_awready%0d", i), awready, 1'b0);
            chk1($sformatf("skew_wready%0d", i), wready, 1'b0);
        end
        wvalid = 1'b1;
        tick();
        chk1("skew_awready_hs", awready, 1'b1);
        chk1("skew_wready_hs", wready, 1'b1);
        chk("skew_pulse", {28'd0, pulse}, 32'h8);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk1("skew_bvalid", bvalid, 1'b1);
        chk("skew_regq3", reg_q[3], 32'hCAFE_0004);
        tick();
        chk1("skew_bdone", bvalid, 1'b0);

        // W without AW is never accepted
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1($sformatf("wonly_wready%0d", i), wready, 1'b0);
        end
        wvalid = 1'b0;
        tick();

        // Write response backpressure with a second write waiting
        bready = 1'b0;
        awaddr = 'h0; wdata = 32'h1111_1111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!awready && n < 20);
        chk1("bp_first_hs", awready, 1'b1);
        tick();
        awaddr = 'h4; wdata = 32'h2222_2222;
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("bp_bvalid%0d", i), bvalid, 1'b1);
            chk("bp_bresp", {30'd0, bresp}, 32'd0);
            chk1($sformatf("bp_noaccept%0d", i), awready, 1'b0);
            tick();
        end
        bready = 1'b1;
        tick();
        chk1("bp_bdone", bvalid, 1'b0);
        tick();
        chk1("bp_second_hs", awready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk1("bp_second_bvalid", bvalid, 1'b1);
        tick();
        chk("bp_regq0", reg_q[0], 32'h1111_1111);
        chk("bp_regq1", reg_q[1], 32'h2222_2222);

        // Read data backpressure
        rready = 1'b0;
        araddr = 'h0; arvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!arready && n < 20);
        chk1("rbp_arready", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("rbp_rvalid%0d", i), rvalid, 1'b1);
            chk($sformatf("rbp_rdata%0d", i), rdata, 32'h1111_1111);
            tick();
        end
        rready = 1'b1;
        tick();
        chk1("rbp_rdone", rvalid, 1'b0);

        // Same-cycle write and read of one register: read sees old value
        awaddr = 'h8; wdata = 32'h7777_7777; wstrb = 4'hF;
        araddr = 'h8;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        chk1("sim_awready", awready, 1'b1);
        chk1("sim_arready", arready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk1("sim_bvalid", bvalid, 1'b1);
        chk1("sim_rvalid", rvalid, 1'b1);
        chk("sim_rdata_old", rdata, 32'h3);
        chk("sim_regq2_new", reg_q[2], 32'h7777_7777);
        tick();

        // Reset while in the write response phase
        bready = 1'b0;
        awaddr = 'hC; wdata = 32'h0000_0099; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!awready && n < 20);
        chk1("mrst_hs", awready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk1("mrst_bvalid_pre", bvalid, 1'b1);
        rst = 1'b1;
        tick();
        chk1("mrst_bvalid", bvalid, 1'b0);
        for (int i = 0; i < 4; i++) chk($sformatf("mrst_reg%0d", i), reg_q[i], 32'd0);
        rst = 1'b0;
        tick();
        do_write('hC, 32'h5A5A_0000, 4'hF, RESP_OKAY, 4'b1000, "post_rst_w");
        chk("post_rst_regq3", reg_q[3], 32'h5A5A_0000);
        do_read('hC, 32'h5A5A_0000, RESP_OKAY, "post_rst_r");

`ifdef AD1PMOD_AXIL_DECERR_EN
        // Out-of-window accesses
        do_write('h10, 32'h0000_00AA, 4'hF, RESP_SLVERR, 4'b0000, "oob_w");
        for (int i = 0; i < 3; i++) chk($sformatf("oob_reg%0d", i), reg_q[i], 32'd0);
        chk("oob_reg3", reg_q[3], 32'h5A5A_0000);
        do_read('h10, 32'd0, RESP_SLVERR, "oob_r");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
